f_le_responder: RTL and testbench
=================================

// Module: f_le_responder
// PURPOSE
//  Multi-cycle floating-point "a <= b" comparator. It sits on the responder side of the
//  compare interface that sorting/min-max FSMs drive, and returns res/err per request.
//  Requests use a valid/ready handshake. The magnitude is scanned MSB-first, CHUNK bits
//  per cycle, so a single narrow comparator is time-shared. Latency is variable.
// PARAMETERS
//  FLEN   64  operand width (IEEE-754 binary, sign|exp|mantissa)
//  EXPW   11  exponent width; mantissa width = FLEN-1-EXPW
//  CHUNK  16  magnitude bits compared per SCAN cycle; NCHUNK = ceil((FLEN-1)/CHUNK)
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous reset, active-high
//  req_valid  in   1     request present
//  req_ready  out  1     responder can accept; high only in IDLE
//  req_a      in   FLEN  operand a
//  req_b      in   FLEN  operand b
//  rsp_valid  out  1     one-cycle pulse; rsp_res/rsp_err valid in this cycle
//  rsp_res    out  1     1 when a <= b; held until the next response
//  rsp_err    out  1     1 when an operand is NaN (see CONFIGURATION); held like rsp_res
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rsp_valid, rsp_res, rsp_err = 0; busy = 0; req_ready = 1.
//  Accept when req_valid && req_ready in cycle k. Capture a and b, then go to CLASSIFY.
//  CLASSIFY (k+1):
//   - Either operand NaN (exp all-ones, mantissa != 0): err=1, res=0, go to RESP.
//   - Both operands zero (sign ignored, +0 == -0): res=1, go to RESP.
//   - Signs differ: res = sign(a); go to RESP.
//   - Otherwise: clear the chunk index, go to SCAN.
//  SCAN:
//   - Magnitudes (FLEN-1 bits) are zero-extended at the MSB to NCHUNK*CHUNK bits.
//   - Each cycle compares chunk[idx], starting from the MSB chunk.
//   - First unequal chunk: res = (mag_a < mag_b) XOR sign. Go to RESP.
//   - Equal chunk and idx == NCHUNK-1: res=1 (equal operands). Go to RESP.
//   - Otherwise idx++.
//  RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready returns in the next cycle.
//  Latency from acceptance: 2 cycles (early decision in CLASSIFY); 2+s cycles after s SCAN cycles.
//   Worst case with defaults: k+6.
//  req_valid while busy is ignored; the operands are not captured. Back-to-back throughput:
//   one request per (latency+1) cycles.
//  The index counter is $clog2(NCHUNK) bits and never wraps past NCHUNK-1.
//  rst in any state aborts the operation: IDLE next cycle, no rsp_valid pulse, results cleared.
// CONFIGURATION
//  F_LE_INF_ERR_EN defined:
//   - An infinite operand (exp all-ones, mantissa 0) also sets err=1.
//   - The compare still completes normally: res is valid, inf ordered as the largest magnitude.
//  F_LE_INF_ERR_EN undefined:
//   - Infinities compare normally with err=0. Only NaN sets err.
// STRUCTURE
//  Package f_le_pkg:
//   - state enum {IDLE, CLASSIFY, SCAN, RESP}
//   - localparams NCHUNK and MANTW
//   - class-flag struct {is_nan, is_inf, is_zero, sign}
//  Sub-module f_le_classify: combinational FLEN -> class-flag struct, instantiated for a and b.
//  Everything else (FSM, chunk mux, result regs) stays in f_le_responder.
// TESTING
//  1. a=3FF0000000000000 (1.0), b=4000000000000000 (2.0)
//     -> rsp_valid at k+3, res=1, err=0.
//  2. a=b=BFF0000000000000 (-1.0)
//     -> all 4 chunks scanned; rsp_valid at k+6, res=1, err=0.
//  3. a=8000000000000000 (-0), b=0000000000000000 (+0)
//     -> rsp_valid at k+2, res=1. Also the swapped pair -> res=1.
//  4. a=7FF8000000000000 (qNaN), b=3FF0000000000000
//     -> rsp_valid at k+2, res=0, err=1.
//  5. a=BFF0000000000000, b=C000000000000000 (-1.0 vs -2.0)
//     -> res=0, err=0.
//     a=7FF0000000000000 (+inf) vs 2.0 -> res=0; err=1 only with F_LE_INF_ERR_EN.
//  6. Protocol: req_valid held high with new operands during busy -> ignored.
//     rst asserted in SCAN -> IDLE next cycle, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/f_le_pkg.sv
// f_le_pkg: shared types and default sizing for the f_le_responder comparator
package f_le_pkg;
  localparam int FLEN_D = 64;
  localparam int EXPW_D = 11;
  localparam int CHUNK_D = 16;
  localparam int MANTW = FLEN_D - 1 - EXPW_D;
  localparam int NCHUNK = (FLEN_D - 1 + CHUNK_D - 1) / CHUNK_D;
  typedef enum logic [1:0] {IDLE, CLASSIFY, SCAN, RESP} state_t;
  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic sign;
  } cls_t;
  function automatic int nchunk(input int flen, input int chunk);
    return (flen - 1 + chunk - 1) / chunk;
  endfunction
endpackage

// File: rtl/f_le_classify.sv
// f_le_classify: combinational IEEE-754 operand classification into class flags
module f_le_classify
  import f_le_pkg::*;
#(
  parameter int FLEN = FLEN_D,
  parameter int EXPW = EXPW_D
) (
  input  logic [FLEN-1:0] x,
  output cls_t            c
);
  logic [EXPW-1:0] e;
  logic [FLEN-2-EXPW:0] m;
  assign e = x[FLEN-2 -: EXPW];
  assign m = x[FLEN-2-EXPW:0];
  assign c = '{is_nan: (&e) & (|m), is_inf: (&e) & ~(|m), is_zero: ~(|x[FLEN-2:0]), sign: x[FLEN-1]};
endmodule

// File: rtl/f_le_responder.sv
// f_le_responder: multi-cycle a<=b float compare, chunked MSB-first scan; F_LE_INF_ERR_EN flags infinities as err
module f_le_responder
  import f_le_pkg::*;
#(
  parameter int FLEN = FLEN_D,
  parameter int EXPW = EXPW_D,
  parameter int CHUNK = CHUNK_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FLEN-1:0] req_a,
  input  logic [FLEN-1:0] req_b,
  output logic            rsp_valid,
  output logic            rsp_res,
  output logic            rsp_err,
  output logic            busy
);
  localparam int NC = nchunk(FLEN, CHUNK);
  localparam int EW = NC * CHUNK;
  localparam int IW = NC > 1 ? $clog2(NC) : 1;
`ifdef F_LE_INF_ERR_EN
  localparam logic INF_EN = 1'b1;
`else
  localparam logic INF_EN = 1'b0;
`endif
  state_t state;
  logic [FLEN-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic err_q;
  cls_t ca, cb;
  logic [EW-1:0] ext_a, ext_b;
  logic [CHUNK-1:0] cha, chb;
  logic inf_err, last;
  f_le_classify #(.FLEN(FLEN), .EXPW(EXPW)) u_cls_a (.x(a_q), .c(ca));
  f_le_classify #(.FLEN(FLEN), .EXPW(EXPW)) u_cls_b (.x(b_q), .c(cb));
  assign ext_a = EW'(a_q[FLEN-2:0]);
  assign ext_b = EW'(b_q[FLEN-2:0]);
  assign inf_err = INF_EN & (ca.is_inf | cb.is_inf);
  assign last = idx == IW'(NC - 1);
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  // select the current magnitude chunk, MSB chunk first
  always_comb begin
    cha = ext_a[(NC - 1 - int'(idx)) * CHUNK +: CHUNK];
    chb = ext_b[(NC - 1 - int'(idx)) * CHUNK +: CHUNK];
  end
  // request FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_res <= 1'b0;
      rsp_err <= 1'b0;
      idx <= '0;
      err_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          a_q <= req_a;
          b_q <= req_b;
          state <= CLASSIFY;
        end
        CLASSIFY: if (ca.is_nan | cb.is_nan) begin
          rsp_res <= 1'b0;
          rsp_err <= 1'b1;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else if (ca.is_zero & cb.is_zero) begin
          rsp_res <= 1'b1;
          rsp_err <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else if (ca.sign != cb.sign) begin
          rsp_res <= ca.sign;
          rsp_err <= inf_err;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else begin
          idx <= '0;
          err_q <= inf_err;
          state <= SCAN;
        end
        SCAN: if (cha != chb || last) begin
          rsp_res <= cha != chb ? (cha < chb) ^ ca.sign : 1'b1;
          rsp_err <= err_q;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else idx <= idx + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_f_le_responder.sv
// tb_f_le_responder: directed-vector bench for f_le_responder
module tb_f_le_responder;
  logic clk = 0, rst = 1, req_valid = 0;
  logic [63:0] req_a = '0, req_b = '0;
  logic req_ready, rsp_valid, rsp_res, rsp_err, busy;
  int n_run = 0, n_fail = 0;
`ifdef F_LE_INF_ERR_EN
  localparam logic INF_ERR = 1'b1;
`else
  localparam logic INF_ERR = 1'b0;
`endif
  f_le_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_res(rsp_res),
    .rsp_err(rsp_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic r, input logic e, input int lat, input bit hold);
    int cyc;
    @(negedge clk);
    chk({tag, " ready"}, 64'(req_ready), 64'd1);
    req_a = a;
    req_b = b;
    req_valid = 1;
    @(posedge clk);
    #1;
    if (hold) begin
      req_a = 64'h7FF8000000000000;
      req_b = 64'h0;
    end else req_valid = 0;
    cyc = 1;
    @(negedge clk);
    while (!rsp_valid && cyc < 20) begin
      if (hold) chk({tag, " busy"}, 64'({busy, req_ready}), 64'b10);
      @(negedge clk);
      cyc++;
    end
    req_valid = 0;
    chk({tag, " lat"}, 64'(cyc), 64'(lat));
    chk({tag, " res"}, 64'(rsp_res), 64'(r));
    chk({tag, " err"}, 64'(rsp_err), 64'(e));
    @(negedge clk);
    chk({tag, " after"}, 64'({rsp_valid, req_ready, busy, rsp_res, rsp_err}), 64'({1'b0, 1'b1, 1'b0, r, e}));
  endtask
  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 64'({rsp_valid, rsp_res, rsp_err, busy, req_ready}), 64'b00001);
    @(negedge clk);
    rst = 0;
    run("1lt2", 64'h3FF0000000000000, 64'h4000000000000000, 1, 0, 3, 0);
    run("2gt1", 64'h4000000000000000, 64'h3FF0000000000000, 0, 0, 3, 0);
    run("eqneg", 64'hBFF0000000000000, 64'hBFF0000000000000, 1, 0, 6, 0);
    run("zero", 64'h8000000000000000, 64'h0000000000000000, 1, 0, 2, 0);
    run("zerosw", 64'h0000000000000000, 64'h8000000000000000, 1, 0, 2, 0);
    run("nan", 64'h7FF8000000000000, 64'h3FF0000000000000, 0, 1, 2, 0);
    run("neg", 64'hBFF0000000000000, 64'hC000000000000000, 0, 0, 3, 0);
    run("inf", 64'h7FF0000000000000, 64'h4000000000000000, 0, INF_ERR, 3, 0);
    run("sgn", 64'hBFF0000000000000, 64'h4000000000000000, 1, 0, 2, 0);
    run("lsbgt", 64'h3FF0000000000001, 64'h3FF0000000000000, 0, 0, 6, 0);
    run("lsblt", 64'h3FF0000000000000, 64'h3FF0000000000001, 1, 0, 6, 0);
    run("chunk2", 64'h3FF0000100000000, 64'h3FF0000000000000, 0, 0, 4, 0);
    run("hold", 64'hBFF0000000000000, 64'hBFF0000000000000, 1, 0, 6, 1);
    @(negedge clk);
    req_a = 64'h3FF0000000000000;
    req_b = 64'h3FF0000000000000;
    req_valid = 1;
    @(posedge clk);
    #1;
    req_valid = 0;
    @(posedge clk);
    #1;
    chk("scan busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst scan", 64'({rsp_valid, rsp_res, rsp_err, busy, req_ready}), 64'b00001);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("rst nopulse", 64'(seen), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
